// File: rtl/egg_timer_pkg.sv
// Shared types for the egg timer: FSM state codes, BCD digit types and time limits.
package egg_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd2_t;

    localparam int SEC_MAX         = 59;
    localparam int MAX_MIN_DEFAULT = 59;

    function automatic bcd2_t to_bcd2(input int v);
        bcd2_t r;
        r.tens = bcd_t'(v / 10);
        r.ones = bcd_t'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter with increment/decrement/hold and programmable wrap limit.
// borrow flags that the next decrement will wrap from 00 up to the limit.
module bcd_mod_counter
    import egg_timer_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc,
    input  logic  dec,
    input  bcd2_t limit,
    output bcd2_t val,
    output logic  borrow
);

    logic at_lim;

    assign at_lim = (val == limit);
    assign borrow = (val == '0);

    // inc has priority; the controller never asserts both together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= '0;
        end else if (inc) begin
            if (at_lim) begin
                val <= '0;
            end else if (val.ones == 4'd9) begin
                val.ones <= 4'd0;
                val.tens <= val.tens + 4'd1;
            end else begin
                val.ones <= val.ones + 4'd1;
            end
        end else if (dec) begin
            if (borrow) begin
                val <= limit;
            end else if (val.ones == 4'd0) begin
                val.ones <= 4'd9;
                val.tens <= val.tens - 4'd1;
            end else begin
                val.ones <= val.ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer controller: set mm:ss, count down on 1 Hz ticks, pause, and hold the
// alarm for ALARM_SECS ticks once the countdown reaches 00:00.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int ALARM_SECS = 5,
    parameter int MAX_MIN    = MAX_MIN_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       cook_time,
    input  logic       start,
    input  logic       minutes_up,
    input  logic       seconds_up,
    output logic [3:0] second_ones,
    output logic [3:0] second_tens,
    output logic [3:0] minute_ones,
    output logic [3:0] minute_tens,
    output logic       enable_timer_cooktime,
    output logic       running,
    output logic       alarm,
    output logic [2:0] state
);

    localparam int    CW         = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam bcd2_t SEC_LIM    = to_bcd2(SEC_MAX);
    localparam bcd2_t MIN_LIM    = to_bcd2(MAX_MIN);
    localparam bcd2_t ONE_SEC    = to_bcd2(1);

    logic [1:0]    rst_sync;
    logic          rst_n;
    state_t        cur_st, state_nxt;
    logic [CW-1:0] alarm_cnt;
    bcd2_t         sec_val, min_val;
    logic          sec_borrow, min_borrow;
    logic          sec_inc, min_inc, run_tick;
    logic          time_zero, last_sec;

    // Assert asynchronously, release two clocks after reset rises
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign time_zero = sec_borrow && min_borrow;
    assign last_sec  = min_borrow && (sec_val == ONE_SEC);

    always_comb begin
        state_nxt = cur_st;
        sec_inc   = 1'b0;
        min_inc   = 1'b0;
        run_tick  = 1'b0;
        case (cur_st)
            ST_IDLE: begin
                if (cook_time)                 state_nxt = ST_SET;
                else if (start && !time_zero)  state_nxt = ST_RUN;
            end
            ST_SET: begin
                sec_inc = seconds_up;
                min_inc = minutes_up;
                if (!cook_time) state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                // a start coinciding with a tick pauses and drops the tick
                if (start) begin
                    state_nxt = ST_PAUSE;
                end else if (tick_1hz) begin
                    run_tick = 1'b1;
                    if (last_sec) state_nxt = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (start)          state_nxt = ST_RUN;
                else if (cook_time) state_nxt = ST_SET;
            end
            ST_DONE: begin
                if (start || (tick_1hz && alarm_cnt == CW'(ALARM_SECS - 1)))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st                <= ST_IDLE;
            enable_timer_cooktime <= 1'b0;
            running               <= 1'b0;
            alarm                 <= 1'b0;
            alarm_cnt             <= '0;
        end else begin
            cur_st                <= state_nxt;
            enable_timer_cooktime <= (state_nxt == ST_SET);
            running               <= (state_nxt == ST_RUN);
            alarm                 <= (state_nxt == ST_DONE);
            if (state_nxt != ST_DONE)
                alarm_cnt <= '0;
            else if (cur_st == ST_DONE && tick_1hz)
                alarm_cnt <= alarm_cnt + CW'(1);
        end
    end

    bcd_mod_counter u_sec (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (sec_inc),
        .dec    (run_tick),
        .limit  (SEC_LIM),
        .val    (sec_val),
        .borrow (sec_borrow)
    );

    bcd_mod_counter u_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (min_inc),
        .dec    (run_tick && sec_borrow),
        .limit  (MIN_LIM),
        .val    (min_val),
        .borrow (min_borrow)
    );

    assign second_ones = sec_val.ones;
    assign second_tens = sec_val.tens;
    assign minute_ones = min_val.ones;
    assign minute_tens = min_val.tens;
    assign state       = cur_st;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: directed scenarios plus random stimulus against a
// total-seconds reference model.
module tb_egg_timer_ctrl;

    localparam int ALARM_SECS = 5;
    localparam int MAX_MIN    = 59;

    logic       clk = 1'b0, reset = 1'b1;
    logic       tick_1hz = 1'b0, cook_time = 1'b0, start = 1'b0;
    logic       minutes_up = 1'b0, seconds_up = 1'b0;
    logic [3:0] second_ones, second_tens, minute_ones, minute_tens;
    logic       enable_timer_cooktime, running, alarm;
    logic [2:0] state;

    int checks = 0, failures = 0;
    int m_st = 0, m_mm = 0, m_ss = 0, m_alarm = 0;

    egg_timer_ctrl #(.ALARM_SECS(ALARM_SECS), .MAX_MIN(MAX_MIN)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .cook_time(cook_time),
        .start(start), .minutes_up(minutes_up), .seconds_up(seconds_up),
        .second_ones(second_ones), .second_tens(second_tens),
        .minute_ones(minute_ones), .minute_tens(minute_tens),
        .enable_timer_cooktime(enable_timer_cooktime), .running(running),
        .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    logic [21:0] dut_vec;
    assign dut_vec = {state, enable_timer_cooktime, running, alarm,
                      minute_tens, minute_ones, second_tens, second_ones};

    function automatic logic [21:0] exp_vec();
        return {3'(m_st), (m_st == 1), (m_st == 2), (m_st == 4),
                4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
    endfunction

    // Model: 0 IDLE, 1 SET, 2 RUN, 3 PAUSE, 4 DONE; time held as minutes and seconds
    task automatic model_clk();
        int t;
        case (m_st)
            0: if (cook_time) m_st = 1;
               else if (start && (m_mm * 60 + m_ss) != 0) m_st = 2;
            1: begin
                if (minutes_up) m_mm = (m_mm + 1) % (MAX_MIN + 1);
                if (seconds_up) m_ss = (m_ss + 1) % 60;
                if (!cook_time) m_st = 0;
            end
            2: if (start) m_st = 3;
               else if (tick_1hz) begin
                   t = m_mm * 60 + m_ss - 1;
                   m_mm = t / 60;
                   m_ss = t % 60;
                   if (t == 0) begin m_st = 4; m_alarm = 0; end
               end
            3: if (start) m_st = 2;
               else if (cook_time) m_st = 1;
            4: if (start) m_st = 0;
               else if (tick_1hz) begin
                   m_alarm++;
                   if (m_alarm == ALARM_SECS) m_st = 0;
               end
            default: m_st = 0;
        endcase
    endtask

    task automatic step();
        model_clk();
        @(posedge clk);
        #1;
        tick_1hz = 0; start = 0; minutes_up = 0; seconds_up = 0;
    endtask

    task automatic test_reset();
        cook_time = 0;
        #2 reset = 0;
        m_st = 0; m_mm = 0; m_ss = 0; m_alarm = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL reset_state: got %h want %h", dut_vec, exp_vec());
        end
        reset = 1;
        repeat (4) step();
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL reset_release: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_set();
        cook_time = 1; step();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) minutes_up = 1; else seconds_up = 1;
            step();
            checks++;
            if (dut_vec !== exp_vec() || enable_timer_cooktime !== 1'b1) begin
                failures++; $display("FAIL set_press%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        cook_time = 0; step();
        checks++;
        if (dut_vec !== {3'd0, 3'b000, 16'h0302}) begin
            failures++; $display("FAIL set_0302: got %h want %h", dut_vec, {3'd0, 3'b000, 16'h0302});
        end
    endtask

    task automatic test_wrap();
        cook_time = 1; step();
        for (int i = 0; i < 80 && !(m_mm == 59 && m_ss == 59); i++) begin
            minutes_up = (m_mm != 59);
            seconds_up = (m_ss != 59);
            step();
        end
        checks++;
        if (dut_vec !== exp_vec() || dut_vec[15:0] !== 16'h5959) begin
            failures++; $display("FAIL wrap_5959: got %h want %h", dut_vec, exp_vec());
        end
        minutes_up = 1; seconds_up = 1; step();
        checks++;
        if (dut_vec !== {3'd1, 3'b100, 16'h0000}) begin
            failures++; $display("FAIL wrap_0000: got %h want %h", dut_vec, {3'd1, 3'b100, 16'h0000});
        end
        cook_time = 0; step();
    endtask

    task automatic test_countdown();
        cook_time = 1; step();
        minutes_up = 1; step();
        cook_time = 0; step();
        start = 1; step();
        checks++;
        if (dut_vec !== {3'd2, 3'b010, 16'h0100}) begin
            failures++; $display("FAIL run_0100: got %h want %h", dut_vec, {3'd2, 3'b010, 16'h0100});
        end
        tick_1hz = 1; step();
        checks++;
        if (dut_vec !== {3'd2, 3'b010, 16'h0059}) begin
            failures++; $display("FAIL run_0059: got %h want %h", dut_vec, {3'd2, 3'b010, 16'h0059});
        end
        for (int i = 0; i < 59; i++) begin
            repeat (2) step();
            tick_1hz = 1; step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL run_tick%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (dut_vec !== {3'd4, 3'b001, 16'h0000}) begin
            failures++; $display("FAIL done_entry: got %h want %h", dut_vec, {3'd4, 3'b001, 16'h0000});
        end
    endtask

    task automatic test_done();
        for (int i = 0; i < ALARM_SECS; i++) begin
            repeat (2) step();
            tick_1hz = 1; step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL done_tick%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (state !== 3'd0 || alarm !== 1'b0) begin
            failures++; $display("FAIL done_timeout: got st=%0d alarm=%b want st=0 alarm=0", state, alarm);
        end
        cook_time = 1; step();
        seconds_up = 1; step();
        seconds_up = 1; step();
        cook_time = 0; step();
        start = 1; step();
        repeat (4) begin tick_1hz = 1; step(); step(); end
        checks++;
        if (dut_vec !== exp_vec() || state !== 3'd4) begin
            failures++; $display("FAIL done_ack_pre: got %h want %h", dut_vec, exp_vec());
        end
        start = 1; step();
        checks++;
        if (dut_vec !== {3'd0, 3'b000, 16'h0000} || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL done_ack: got %h want %h", dut_vec, {3'd0, 3'b000, 16'h0000});
        end
    endtask

    task automatic test_pause();
        cook_time = 1; step();
        repeat (10) begin seconds_up = 1; step(); end
        cook_time = 0; step();
        start = 1; step();
        start = 1; tick_1hz = 1; step();
        checks++;
        if (dut_vec !== {3'd3, 3'b000, 16'h0010}) begin
            failures++; $display("FAIL pause_enter: got %h want %h", dut_vec, {3'd3, 3'b000, 16'h0010});
        end
        for (int i = 0; i < 3; i++) begin
            tick_1hz = 1; step();
            checks++;
            if (dut_vec !== {3'd3, 3'b000, 16'h0010}) begin
                failures++; $display("FAIL pause_hold%0d: got %h want %h", i, dut_vec, {3'd3, 3'b000, 16'h0010});
            end
        end
        start = 1; step();
        tick_1hz = 1; step();
        checks++;
        if (dut_vec !== {3'd2, 3'b010, 16'h0009}) begin
            failures++; $display("FAIL resume_0009: got %h want %h", dut_vec, {3'd2, 3'b010, 16'h0009});
        end
        cook_time = 1; minutes_up = 1; seconds_up = 1; step();
        cook_time = 0;
        checks++;
        if (dut_vec !== exp_vec() || state !== 3'd2) begin
            failures++; $display("FAIL run_ignore: got %h want %h", dut_vec, exp_vec());
        end
        start = 1; step();
        cook_time = 1; step();
        checks++;
        if (dut_vec !== {3'd1, 3'b100, 16'h0009}) begin
            failures++; $display("FAIL pause_to_set: got %h want %h", dut_vec, {3'd1, 3'b100, 16'h0009});
        end
        cook_time = 0; step();
    endtask

    task automatic test_reset_mid_run();
        cook_time = 1; step();
        for (int i = 0; i < 80 && !(m_mm == 2 && m_ss == 30); i++) begin
            minutes_up = (m_mm != 2);
            seconds_up = (m_ss != 30);
            step();
        end
        cook_time = 0; step();
        start = 1; step();
        checks++;
        if (dut_vec !== {3'd2, 3'b010, 16'h0230}) begin
            failures++; $display("FAIL run_0230: got %h want %h", dut_vec, {3'd2, 3'b010, 16'h0230});
        end
        #2 reset = 0;
        #1;
        m_st = 0; m_mm = 0; m_ss = 0; m_alarm = 0;
        checks++;
        if (dut_vec !== 22'h0) begin
            failures++; $display("FAIL async_reset: got %h want %h", dut_vec, 22'h0);
        end
        repeat (2) step();
        reset = 1;
        repeat (4) step();
        start = 1; step();
        checks++;
        if (dut_vec !== 22'h0 || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL start_zero: got %h want %h", dut_vec, 22'h0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            tick_1hz   = ($urandom_range(0, 5) == 0);
            start      = ($urandom_range(0, 11) == 0);
            minutes_up = ($urandom_range(0, 2) == 0);
            seconds_up = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 24) == 0) cook_time = !cook_time;
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL random%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        cook_time = 0;
    endtask

    initial begin
        test_reset();
        test_set();
        test_wrap();
        test_countdown();
        test_done();
        test_pause();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
